alu_seq: RTL and testbench

- Command-driven sequencer for the shared 16-bit ALU and its PSR flag register.
- Accepts one register-to-register instruction at a time over a valid/ready handshake and reads operands from an internal 8-entry register file.
- Drives the combinational ALU's operand and one-hot select inputs for exactly one cycle, then writes the result back and returns result and flags over a valid/ready response channel.
- Sits between the instruction source and the ALU + PSR pair. The PSR is fed with the same alu_sel and flags, so the flag register updates only on sequenced operations.

---
 rtl/alu_seq.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- command sequencer for the shared ALU and its PSR flag register.
//
// Accepts one register-to-register instruction at a time over a valid/ready
// command channel. Operands come from an internal 8-entry register file. The
// sequencer drives the external combinational ALU for exactly one cycle, writes
// the result back, and returns result and flags on a valid/ready response
// channel. The PSR watches the same alu_sel, so flags change only on
// sequenced operations.
//
// Optional build macro:
//   ALU_SEQ_PERF_EN - adds perf_cnt[15:0], a saturating count of response
//                     handshakes. When the macro is undefined the port and the
//                     counter are absent.
//
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_ready is high only in IDLE
//   cmd_op/rd/rs/rt     opcode, destination index, source A/B indices
//   cmd_imm             immediate operand for MOVI
//   alu_a, alu_b        ALU operands, registered
//   alu_sel             one-hot ALU/PSR select, non-zero only during EXEC
//   alu_out, alu_flcnz  ALU result and flags {F,L,C,N,Z}
//   rsp_valid/ready     response handshake
//   rsp_data/flags/err  result, captured flags, reserved-opcode error
//   perf_cnt            handshake counter (ALU_SEQ_PERF_EN only)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_rd,
  input  logic [2:0]        cmd_rs,
  input  logic [2:0]        cmd_rt,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flcnz,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_flags,
  output logic              rsp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_CMP  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MOVI = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  // One-hot select shared by the ALU and the PSR.
  function automatic logic [5:0] sel_code(input op_t op);
    logic [5:0] code;
    code = 6'b000000;
    case (op)
      OP_ADD:  code = 6'b100000;
      OP_SUB:  code = 6'b010000;
      OP_CMP:  code = 6'b001000;
      OP_AND:  code = 6'b000100;
      OP_OR:   code = 6'b000010;
      OP_XOR:  code = 6'b000001;
      default: code = 6'b000000;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [2:0]          rd_q, rd_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [5:0]          alu_sel_q, alu_sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]          rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;

  // Register file and its single write port.
  logic [DATA_W-1:0]   regs_q [8];
  logic                wr_en;
  logic [2:0]          wr_idx;
  logic [DATA_W-1:0]   wr_data;

  op_t                 cmd_op_e;
  logic                accept;
  logic                rsp_fire;

  assign cmd_op_e = op_t'(cmd_op);
  // cmd_ready_q is only ever high in IDLE; the state term keeps that explicit.
  assign accept   = cmd_valid && cmd_ready_q && (state_q == S_IDLE);
  // rsp_ready is meaningless while no response is offered.
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // MOVI and the reserved opcode skip the ALU cycle entirely.
          if (cmd_op_e == OP_MOVI || cmd_op_e == OP_RSVD) begin
            state_d = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic (next values of the registered outputs and the
  // register-file write port)
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d        = op_q;
    rd_d        = rd_q;
    cmd_ready_d = (state_d == S_IDLE);
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    wr_idx      = rd_q;
    wr_data     = alu_out;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op_e;
          rd_d    = cmd_rd;
          // Operands are read at the accept edge, so rd == rs/rt sees the
          // old value.
          alu_a_d = regs_q[cmd_rs];
          alu_b_d = regs_q[cmd_rt];
          case (cmd_op_e)
            OP_MOVI: begin
              wr_en       = 1'b1;
              wr_idx      = cmd_rd;
              wr_data     = cmd_imm;
              rsp_valid_d = 1'b1;
              rsp_data_d  = cmd_imm;
              rsp_flags_d = 5'b00000;
              rsp_err_d   = 1'b0;
            end
            OP_RSVD: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_flags_d = 5'b00000;
              rsp_err_d   = 1'b1;
            end
            default: begin
              alu_sel_d = sel_code(cmd_op_e);
            end
          endcase
        end
      end

      S_EXEC: begin
        // The ALU has had a full cycle on stable operands; capture it now.
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_flags_d = alu_flcnz;
        rsp_err_d   = 1'b0;
        alu_sel_d   = 6'b000000;
        alu_a_d     = '0;
        alu_b_d     = '0;
        // CMP only updates flags; the destination keeps its value.
        wr_en       = (op_q != OP_CMP);
        wr_idx      = rd_q;
        wr_data     = alu_out;
      end

      S_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q        <= OP_ADD;
      rd_q        <= 3'd0;
      cmd_ready_q <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 6'b000000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 5'b00000;
      rsp_err_q   <= 1'b0;
    end else begin
      op_q        <= op_d;
      rd_q        <= rd_d;
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // NOTE: this small array is reset entry by entry because software relies on
  // a known RST_VAL in every register; larger RAMs would normally not be reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating response-handshake counter
  // ---------------------------------------------------------------------------
  logic [15:0] perf_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      perf_cnt_q <= 16'h0000;
    end else if (rsp_fire && (perf_cnt_q != 16'hFFFF)) begin
      perf_cnt_q <= perf_cnt_q + 16'd1;
    end
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq.
//
// A small behavioural ALU stand-in answers the sequencer's alu_sel/alu_a/alu_b.
// SUB and CMP compute b - a; flags are {F,L,C,N,Z} with F = signed overflow,
// L/C = b < a unsigned, N = b < a signed, Z = a == b (CMP); ADD reports
// carry and overflow; logic ops report no flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int DW = 16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_CMP  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MOVI = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op, cmd_rd, cmd_rs, cmd_rt;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [5:0]    alu_sel;
  logic [4:0]    alu_flcnz;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [4:0]    rsp_flags;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]   perf_cnt;
`endif

  alu_seq #(.DATA_W(DW), .RST_VAL('0)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_flcnz (alu_flcnz),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stand-in.
  always_comb begin
    logic [DW:0]   sum;
    logic [DW-1:0] diff;
    logic          ovf_sub;
    alu_out   = '0;
    alu_flcnz = 5'b00000;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    diff      = alu_b - alu_a;
    ovf_sub   = (alu_b[DW-1] != alu_a[DW-1]) && (diff[DW-1] != alu_b[DW-1]);
    case (alu_sel)
      6'b100000: begin
        alu_out   = sum[DW-1:0];
        alu_flcnz = {(alu_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != alu_a[DW-1]),
                     1'b0, sum[DW], 1'b0, 1'b0};
      end
      6'b010000: begin
        alu_out   = diff;
        alu_flcnz = {ovf_sub, 1'b0, (alu_b < alu_a), 1'b0, 1'b0};
      end
      6'b001000: begin
        alu_out   = diff;
        alu_flcnz = {ovf_sub, (alu_b < alu_a), (alu_b < alu_a),
                     ($signed(alu_b) < $signed(alu_a)), (alu_a == alu_b)};
      end
      6'b000100: alu_out = alu_a & alu_b;
      6'b000010: alu_out = alu_a | alu_b;
      6'b000001: alu_out = alu_a ^ alu_b;
      default:   alu_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  // Results of the most recent command.
  logic [DW-1:0] r_data;
  logic [4:0]    r_flags;
  logic          r_err;
  int            r_lat;
  int            r_sel_cnt;
  logic [5:0]    r_sel;
  logic [DW-1:0] r_a, r_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, collect its response, optionally stall rsp_ready for
  // `hold` cycles while a stray command is offered, then complete the handshake.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic [DW-1:0] imm, input int hold);
    bit got;
    r_sel_cnt = 0;
    r_sel     = 6'b0;
    r_lat     = 0;
    r_a       = '0;
    r_b       = '0;
    got       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("cmd_ready_wait", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_imm   = imm;
    got       = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (alu_sel != 6'b0) begin
        r_sel_cnt++;
        r_sel = alu_sel;
        r_a   = alu_a;
        r_b   = alu_b;
      end
      if (rsp_valid) begin
        r_lat = k;
        got   = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("rsp_valid_wait", 32'd0, 32'd1);
      return;
    end
    r_data  = rsp_data;
    r_flags = rsp_flags;
    r_err   = rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        // Stray command while busy: must be ignored.
        cmd_valid = 1'b1;
        cmd_op    = OP_MOVI;
        cmd_rd    = 3'd3;
        cmd_imm   = 16'hFFFF;
      end
      @(negedge clk);
      check("hold.valid",     {31'd0, rsp_valid}, 32'd1);
      check("hold.data",      {16'd0, rsp_data},  {16'd0, r_data});
      check("hold.flags",     {27'd0, rsp_flags}, {27'd0, r_flags});
      check("hold.cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold.alu_sel",   {26'd0, alu_sel},   32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    n_hs++;
    check("hs.valid_clr", {31'd0, rsp_valid}, 32'd0);
    check("hs.cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic exp_rsp(input string name, input logic [DW-1:0] data,
                         input logic [4:0] flags, input logic err,
                         input int lat, input logic [5:0] sel);
    check({name, ".data"},    {16'd0, r_data},  {16'd0, data});
    check({name, ".flags"},   {27'd0, r_flags}, {27'd0, flags});
    check({name, ".err"},     {31'd0, r_err},   {31'd0, err});
    check({name, ".lat"},     r_lat,            lat);
    check({name, ".sel"},     {26'd0, r_sel},   {26'd0, sel});
    check({name, ".sel_cnt"}, r_sel_cnt,        (sel != 6'b0) ? 32'd1 : 32'd0);
  endtask

  // Read a register via OR Rx,Rx -> Rx (rewrites the same value).
  task automatic probe(input string name, input logic [2:0] idx, input logic [DW-1:0] exp);
    do_cmd(OP_OR, idx, idx, idx, '0, 0);
    check(name, {16'd0, r_data}, {16'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs    = '0;
    cmd_rt    = '0;
    cmd_imm   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_data",  {16'd0, rsp_data},  32'd0);
    check("rst.rsp_flags", {27'd0, rsp_flags}, 32'd0);
    check("rst.rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst.alu_a",     {16'd0, alu_a},     32'd0);
    check("rst.alu_b",     {16'd0, alu_b},     32'd0);
    check("rst.alu_sel",   {26'd0, alu_sel},   32'd0);
    rst = 1'b0;

    // Load operands.
    do_cmd(OP_MOVI, 3'd1, 3'd0, 3'd0, 16'h46d3, 0);
    exp_rsp("movi_r1", 16'h46d3, 5'h00, 1'b0, 1, 6'b000000);
    do_cmd(OP_MOVI, 3'd2, 3'd0, 3'd0, 16'hc9ba, 0);
    exp_rsp("movi_r2", 16'hc9ba, 5'h00, 1'b0, 1, 6'b000000);

    // ADD with a stalled response and a stray command during the stall.
    do_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, '0, 5);
    exp_rsp("add", 16'h108d, 5'h04, 1'b0, 2, 6'b100000);
    check("add.alu_a", {16'd0, r_a}, 32'h46d3);
    check("add.alu_b", {16'd0, r_b}, 32'hc9ba);
    check("add.a_clr", {16'd0, alu_a}, 32'd0);
    probe("add.r3", 3'd3, 16'h108d);

    do_cmd(OP_SUB, 3'd3, 3'd1, 3'd2, '0, 0);
    exp_rsp("sub", 16'h82e7, 5'h00, 1'b0, 2, 6'b010000);
    probe("sub.r3", 3'd3, 16'h82e7);

    do_cmd(OP_AND, 3'd3, 3'd1, 3'd2, '0, 0);
    exp_rsp("and", 16'h4092, 5'h00, 1'b0, 2, 6'b000100);
    probe("and.r3", 3'd3, 16'h4092);

    do_cmd(OP_OR, 3'd3, 3'd1, 3'd2, '0, 0);
    exp_rsp("or", 16'hcffb, 5'h00, 1'b0, 2, 6'b000010);
    probe("or.r3", 3'd3, 16'hcffb);

    do_cmd(OP_XOR, 3'd3, 3'd1, 3'd2, '0, 0);
    exp_rsp("xor", 16'h8f69, 5'h00, 1'b0, 2, 6'b000001);
    probe("xor.r3", 3'd3, 16'h8f69);

    // CMP never writes its destination.
    do_cmd(OP_CMP, 3'd5, 3'd1, 3'd2, '0, 0);
    exp_rsp("cmp1", 16'h82e7, 5'h02, 1'b0, 2, 6'b001000);
    probe("cmp1.r5", 3'd5, 16'h0000);

    do_cmd(OP_MOVI, 3'd4, 3'd0, 3'd0, 16'h96c4, 0);
    exp_rsp("movi_r4", 16'h96c4, 5'h00, 1'b0, 1, 6'b000000);
    do_cmd(OP_MOVI, 3'd6, 3'd0, 3'd0, 16'h5d3f, 0);
    exp_rsp("movi_r6", 16'h5d3f, 5'h00, 1'b0, 1, 6'b000000);
    do_cmd(OP_CMP, 3'd0, 3'd4, 3'd6, '0, 0);
    exp_rsp("cmp2", 16'hc67b, 5'h1c, 1'b0, 2, 6'b001000);
    probe("cmp2.r0", 3'd0, 16'h0000);

    // Reserved opcode: error, no write.
    do_cmd(OP_RSVD, 3'd1, 3'd2, 3'd3, 16'h1234, 0);
    exp_rsp("rsvd", 16'h0000, 5'h00, 1'b1, 1, 6'b000000);
    probe("rsvd.r1", 3'd1, 16'h46d3);

    // rd == rs: old R1 read at accept, result visible to the next command.
    do_cmd(OP_ADD, 3'd1, 3'd1, 3'd2, '0, 0);
    exp_rsp("haz", 16'h108d, 5'h04, 1'b0, 2, 6'b100000);
    probe("haz.r1", 3'd1, 16'h108d);

`ifdef ALU_SEQ_PERF_EN
    check("perf.count", {16'd0, perf_cnt}, n_hs);
`endif

    // Reset during EXEC of ADD R1,R2 -> R7.
    @(negedge clk);
    check("mid.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_rd    = 3'd7;
    cmd_rs    = 3'd1;
    cmd_rt    = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid.exec_sel", {26'd0, alu_sel}, 32'h20);
    rst = 1'b1;
    #1;
    check("mid.rst_sel",       {26'd0, alu_sel},   32'd0);
    check("mid.rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid.rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid.rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid.rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef ALU_SEQ_PERF_EN
    check("mid.perf", {16'd0, perf_cnt}, 32'd0);
`endif
    probe("mid.r7", 3'd7, 16'h0000);
    probe("mid.r1", 3'd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
